regfile_8x2r1w: RTL and testbench



---
 rtl/regfile_8x2r1w_if.sv | 39 +++
 rtl/regfile_8x2r1w.sv | 92 +++++++++
 tb/tb_regfile_8x2r1w.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_8x2r1w_if.sv
// ============================================================================
// Module      : regfile_8x2r1w_if
// Description : Operand/result bus for the 8x2r1w register file.
//               One write port, two read selectors, the side-B immediate
//               and the registered read outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_8x2r1w_if #(
   parameter int WORD_SIZE = 8,
   parameter int NUM_REGS  = 8
);
   logic                 wr_en;
   logic [2:0]           wr_sel;
   logic [WORD_SIZE-1:0] wr_data;
   logic                 rd_en;
   logic [2:0]           rd_a_sel;
   logic [3:0]           rd_b_sel;
   logic [WORD_SIZE-1:0] imm8;
   logic [WORD_SIZE-1:0] rd_a_data;
   logic [WORD_SIZE-1:0] rd_b_data;
   logic                 rd_valid;
   logic [NUM_REGS-1:0]  written;

   // Datapath side: drives write/read requests, consumes operands
   modport master (
      output wr_en, wr_sel, wr_data, rd_en, rd_a_sel, rd_b_sel, imm8,
      input  rd_a_data, rd_b_data, rd_valid, written
   );

   // Register file side
   modport slave (
      input  wr_en, wr_sel, wr_data, rd_en, rd_a_sel, rd_b_sel, imm8,
      output rd_a_data, rd_b_data, rd_valid, written
   );
endinterface

`default_nettype wire

// File: rtl/regfile_8x2r1w.sv
// ============================================================================
// Module      : regfile_8x2r1w
// Description : 8-entry register file, one write port, two registered read
//               ports (side A, side B). Side B code 8 selects the immediate,
//               codes 9-15 return zero.
//               Optional macro REGFILE_BYPASS_EN: same-cycle write data is
//               forwarded to a read of the same register. Undefined, a read
//               returns the pre-write value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_8x2r1w #(
   parameter int WORD_SIZE = 8,
   parameter int NUM_REGS  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   regfile_8x2r1w_if.slave       bus
);

   localparam logic [3:0] C_B_SEL_IMM = 4'd8;

   logic [NUM_REGS-1:0][WORD_SIZE-1:0] regs_d,      regs_q;
   logic [NUM_REGS-1:0]                written_d,   written_q;
   logic [WORD_SIZE-1:0]               rd_a_data_d, rd_a_data_q;
   logic [WORD_SIZE-1:0]               rd_b_data_d, rd_b_data_q;
   logic                               rd_valid_d,  rd_valid_q;
   logic [WORD_SIZE-1:0]               a_src;
   logic [WORD_SIZE-1:0]               b_src;

   // Operand source selection, with optional write-through forwarding
   always_comb begin
      a_src = regs_q[bus.rd_a_sel];
      b_src = '0;
      if (!bus.rd_b_sel[3]) begin
         b_src = regs_q[bus.rd_b_sel[2:0]];
      end else if (bus.rd_b_sel == C_B_SEL_IMM) begin
         b_src = bus.imm8;
      end
`ifdef REGFILE_BYPASS_EN
      if (bus.wr_en && (bus.wr_sel == bus.rd_a_sel)) begin
         a_src = bus.wr_data;
      end
      if (bus.wr_en && !bus.rd_b_sel[3] && (bus.wr_sel == bus.rd_b_sel[2:0])) begin
         b_src = bus.wr_data;
      end
`endif
   end

   // Next-state for storage, written bitmap and read outputs
   always_comb begin
      regs_d      = regs_q;
      written_d   = written_q;
      rd_a_data_d = rd_a_data_q;
      rd_b_data_d = rd_b_data_q;
      rd_valid_d  = bus.rd_en;
      if (bus.wr_en) begin
         regs_d[bus.wr_sel]    = bus.wr_data;
         written_d[bus.wr_sel] = 1'b1;
      end
      if (bus.rd_en) begin
         rd_a_data_d = a_src;
         rd_b_data_d = b_src;
      end
   end

   // State registers; reset clears everything and wins over a pending write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q      <= '0;
         written_q   <= '0;
         rd_a_data_q <= '0;
         rd_b_data_q <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         written_q   <= written_d;
         rd_a_data_q <= rd_a_data_d;
         rd_b_data_q <= rd_b_data_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   assign bus.rd_a_data = rd_a_data_q;
   assign bus.rd_b_data = rd_b_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.written   = written_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_8x2r1w.sv
// ============================================================================
// Module      : tb_regfile_8x2r1w
// Description : Self-checking bench for regfile_8x2r1w. Expected read
//               results are pushed to a queue when a read is driven and
//               popped when the DUT presents rd_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_8x2r1w;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_8x2r1w_if #(.WORD_SIZE(8), .NUM_REGS(8)) bus ();

   regfile_8x2r1w #(.WORD_SIZE(8), .NUM_REGS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t       sb[$];
   logic [7:0] model[8];
   logic [7:0] written_m;
   logic [7:0] last_a, last_b;
   int         total = 0;
   int         bad   = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      written_m = 8'h00;
   endtask

   // Drive one clock of stimulus; a read pushes its expected operands
   task automatic drive(input logic we, input logic [2:0] ws, input logic [7:0] wd,
                        input logic re, input logic [2:0] as, input logic [3:0] bs,
                        input logic [7:0] im);
      exp_t e;
      bus.wr_en = we; bus.wr_sel = ws; bus.wr_data = wd;
      bus.rd_en = re; bus.rd_a_sel = as; bus.rd_b_sel = bs; bus.imm8 = im;
      if (re) begin
         e.a = model[as];
         if (bs < 4'd8)       e.b = model[bs[2:0]];
         else if (bs == 4'd8) e.b = im;
         else                 e.b = 8'h00;
`ifdef REGFILE_BYPASS_EN
         if (we && ws == as) e.a = wd;
         if (we && bs < 4'd8 && bs[2:0] == ws) e.b = wd;
`endif
         sb.push_back(e);
      end
      step();
      if (we) begin
         model[ws]     = wd;
         written_m[ws] = 1'b1;
      end
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      bus.wr_en = 0; bus.rd_en = 0; bus.wr_sel = 0; bus.wr_data = 0;
      bus.rd_a_sel = 0; bus.rd_b_sel = 0; bus.imm8 = 0;
      clear_model();
      repeat (2) step();
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.rd_valid); end
      total++; if (bus.written !== 8'h00) begin bad++; $display("FAIL reset_written: got %h want 00", bus.written); end
      rst = 1'b0;
      drive(1, 3'd1, 8'h12, 0, 0, 0, 0);
      drive(1, 3'd4, 8'h34, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 3'd1, 4'd4, 0);
      e = sb.pop_front();
      total++; if (bus.rd_a_data !== e.a || bus.rd_b_data !== e.b) begin
         bad++; $display("FAIL pre_reset_read: got %h/%h want %h/%h", bus.rd_a_data, bus.rd_b_data, e.a, e.b); end
      // asynchronous reset in the middle of a cycle
      #2 rst = 1'b1;
      #1;
      clear_model();
      total++; if (bus.rd_a_data !== 8'h00 || bus.rd_b_data !== 8'h00) begin
         bad++; $display("FAIL async_reset_data: got %h/%h want 00/00", bus.rd_a_data, bus.rd_b_data); end
      total++; if (bus.rd_valid !== 1'b0 || bus.written !== 8'h00) begin
         bad++; $display("FAIL async_reset_flags: got valid=%b written=%h want 0/00", bus.rd_valid, bus.written); end
      // strobes ignored while reset held
      bus.wr_en = 1; bus.wr_sel = 3'd5; bus.wr_data = 8'hEE; bus.rd_en = 1; bus.rd_a_sel = 3'd1;
      step();
      total++; if (bus.rd_valid !== 1'b0 || bus.written !== 8'h00 || bus.rd_a_data !== 8'h00) begin
         bad++; $display("FAIL reset_hold: got valid=%b written=%h a=%h want 0/00/00", bus.rd_valid, bus.written, bus.rd_a_data); end
      bus.wr_en = 0; bus.rd_en = 0;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 0, 1, i[2:0], {1'b0, 3'(7 - i)}, 0);
         if (sb.size() == 0) begin total++; bad++; $display("FAIL post_reset_sb: got empty want entry"); end
         else begin
            e = sb.pop_front();
            total++; if (bus.rd_a_data !== e.a || bus.rd_b_data !== e.b || bus.rd_valid !== 1'b1) begin
               bad++; $display("FAIL post_reset_read r%0d: got %h/%h v=%b want %h/%h v=1", i, bus.rd_a_data, bus.rd_b_data, bus.rd_valid, e.a, e.b); end
         end
      end
   endtask

   task automatic test_basic();
      exp_t e;
      drive(1, 3'd3, 8'hA5, 0, 0, 0, 0);
      drive(1, 3'd6, 8'h3C, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 3'd3, 4'd6, 0);
      e = sb.pop_front();
      total++; if (bus.rd_a_data !== e.a || bus.rd_b_data !== e.b) begin
         bad++; $display("FAIL basic_read: got %h/%h want %h/%h", bus.rd_a_data, bus.rd_b_data, e.a, e.b); end
      total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", bus.rd_valid); end
      total++; if (bus.written !== 8'b0100_1000) begin bad++; $display("FAIL basic_written: got %b want 01001000", bus.written); end
      step();
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL valid_one_cycle: got %b want 0", bus.rd_valid); end
   endtask

   task automatic test_imm_nc();
      exp_t e;
      drive(0, 0, 0, 1, 3'd6, 4'd8, 8'h7E);
      e = sb.pop_front();
      total++; if (bus.rd_a_data !== e.a || bus.rd_b_data !== e.b) begin
         bad++; $display("FAIL imm_read: got %h/%h want %h/%h", bus.rd_a_data, bus.rd_b_data, e.a, e.b); end
      for (int s = 9; s < 16; s += 3) begin
         drive(0, 0, 0, 1, 3'd3, 4'(s), 8'h55);
         e = sb.pop_front();
         total++; if (bus.rd_b_data !== e.b || bus.rd_a_data !== e.a) begin
            bad++; $display("FAIL nc_read sel%0d: got %h/%h want %h/%h", s, bus.rd_a_data, bus.rd_b_data, e.a, e.b); end
      end
   endtask

   task automatic test_hold();
      exp_t e;
      drive(0, 0, 0, 1, 3'd3, 4'd8, 8'hC3);
      e = sb.pop_front();
      last_a = e.a; last_b = e.b;
      total++; if (bus.rd_a_data !== e.a || bus.rd_b_data !== e.b) begin
         bad++; $display("FAIL hold_setup: got %h/%h want %h/%h", bus.rd_a_data, bus.rd_b_data, e.a, e.b); end
      for (int i = 0; i < 3; i++) begin
         drive(1, 3'd7, 8'h5A, 0, 3'(i + 5), 4'(i + 6), 8'h99);
         total++; if (bus.rd_a_data !== last_a || bus.rd_b_data !== last_b || bus.rd_valid !== 1'b0) begin
            bad++; $display("FAIL hold_cycle%0d: got %h/%h v=%b want %h/%h v=0", i, bus.rd_a_data, bus.rd_b_data, bus.rd_valid, last_a, last_b); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         drive(1, 3'(i), 8'(8'h20 + i), 1, 3'(7 - i), 4'(i), 8'h00);
         e = sb.pop_front();
         total++; if (bus.rd_a_data !== e.a || bus.rd_b_data !== e.b || bus.rd_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_read%0d: got %h/%h v=%b want %h/%h v=1", i, bus.rd_a_data, bus.rd_b_data, bus.rd_valid, e.a, e.b); end
      end
   endtask

   task automatic test_hazard();
      exp_t e;
      drive(1, 3'd2, 8'h11, 0, 0, 0, 0);
      drive(1, 3'd2, 8'h99, 1, 3'd2, 4'd2, 8'h00);
      e = sb.pop_front();
      total++; if (bus.rd_a_data !== e.a || bus.rd_b_data !== e.b) begin
         bad++; $display("FAIL hazard_same_cycle: got %h/%h want %h/%h", bus.rd_a_data, bus.rd_b_data, e.a, e.b); end
      // different registers in one cycle never interfere
      drive(1, 3'd5, 8'h77, 1, 3'd4, 4'd3, 8'h00);
      e = sb.pop_front();
      total++; if (bus.rd_a_data !== e.a || bus.rd_b_data !== e.b) begin
         bad++; $display("FAIL hazard_diff_reg: got %h/%h want %h/%h", bus.rd_a_data, bus.rd_b_data, e.a, e.b); end
      drive(0, 0, 0, 1, 3'd2, 4'd5, 8'h00);
      e = sb.pop_front();
      total++; if (bus.rd_a_data !== 8'h99 || bus.rd_b_data !== e.b) begin
         bad++; $display("FAIL hazard_followup: got %h/%h want 99/%h", bus.rd_a_data, bus.rd_b_data, e.b); end
      total++; if (bus.written !== written_m) begin
         bad++; $display("FAIL written_map: got %b want %b", bus.written, written_m); end
   endtask

   task automatic test_write_reset_collision();
      exp_t e;
      drive(1, 3'd0, 8'h42, 0, 0, 0, 0);
      rst = 1'b1;
      bus.wr_en = 1'b1; bus.wr_sel = 3'd0; bus.wr_data = 8'hFF;
      step();
      bus.wr_en = 1'b0;
      rst = 1'b0;
      clear_model();
      total++; if (bus.written !== 8'h00) begin
         bad++; $display("FAIL collision_written: got %b want 00000000", bus.written); end
      drive(0, 0, 0, 1, 3'd0, 4'd0, 8'h00);
      e = sb.pop_front();
      total++; if (bus.rd_a_data !== e.a || bus.rd_b_data !== e.b) begin
         bad++; $display("FAIL collision_read: got %h/%h want %h/%h", bus.rd_a_data, bus.rd_b_data, e.a, e.b); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_imm_nc();
      test_hold();
      test_back_to_back();
      test_hazard();
      test_write_reset_collision();
      total++; if (sb.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
